// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : ID-stage hazard controller. Handles operand forwarding,
//             load-use stalls, branch bubbles and iterative-multiply sequencing.
//  Options  : define HAZ_STAT_EN to add the stall_cnt statistics output.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int RW      = 5
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [RW-1:0] id_rn,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          id_is_mul,
    input  logic          btaken,
    output logic          wpcir,
    output logic          id_bubble,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          mul_start,
`ifdef HAZ_STAT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          mul_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 2);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          exe_wreg_q, exe_wreg_d, exe_m2reg_q, exe_m2reg_d;
    logic [RW-1:0] exe_rn_q, exe_rn_d;
    logic          mem_wreg_q, mem_wreg_d, mem_m2reg_q, mem_m2reg_d;
    logic [RW-1:0] mem_rn_q, mem_rn_d;

    logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
    logic lu_stall, mul_stall, issue;

    // A slot only hits when it writes a real register; $0 never forwards.
    always_comb begin
        exe_hit_rs = exe_wreg_q && (exe_rn_q != '0) && (exe_rn_q == id_rs);
        exe_hit_rt = exe_wreg_q && (exe_rn_q != '0) && (exe_rn_q == id_rt);
        mem_hit_rs = mem_wreg_q && (mem_rn_q != '0) && (mem_rn_q == id_rs);
        mem_hit_rt = mem_wreg_q && (mem_rn_q != '0) && (mem_rn_q == id_rt);
    end

    always_comb begin
        if (exe_hit_rs && !exe_m2reg_q && id_rs_used) fwda = 2'b01;
        else if (mem_hit_rs && !mem_m2reg_q)          fwda = 2'b10;
        else if (mem_hit_rs && mem_m2reg_q)           fwda = 2'b11;
        else                                          fwda = 2'b00;

        if (exe_hit_rt && !exe_m2reg_q && id_rt_used) fwdb = 2'b01;
        else if (mem_hit_rt && !mem_m2reg_q)          fwdb = 2'b10;
        else if (mem_hit_rt && mem_m2reg_q)           fwdb = 2'b11;
        else                                          fwdb = 2'b00;
    end

    always_comb begin
        lu_stall  = exe_m2reg_q && ((id_rs_used && exe_hit_rs) || (id_rt_used && exe_hit_rt));
        mul_stall = (state_q == ST_BUSY);
        wpcir     = !(lu_stall || mul_stall);
        id_bubble = lu_stall || mul_stall || btaken;
        issue     = wpcir && !id_bubble;
        mul_start = issue && id_is_mul;
        mul_busy  = (state_q != ST_IDLE);
    end

    // A mul may issue from DONE as well as IDLE, restarting the sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_BUSY;
                    cnt_d   = MUL_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_DONE: begin
                if (mul_start) begin
                    state_d = ST_BUSY;
                    cnt_d   = MUL_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // While the multiplier runs, the mul stays parked in EXE and MEM drains.
    always_comb begin
        exe_wreg_d  = exe_wreg_q;
        exe_rn_d    = exe_rn_q;
        exe_m2reg_d = exe_m2reg_q;
        mem_wreg_d  = 1'b0;
        mem_rn_d    = '0;
        mem_m2reg_d = 1'b0;
        if (!mul_stall) begin
            mem_wreg_d  = exe_wreg_q;
            mem_rn_d    = exe_rn_q;
            mem_m2reg_d = exe_m2reg_q;
            exe_wreg_d  = issue ? id_wreg  : 1'b0;
            exe_rn_d    = issue ? id_rn    : '0;
            exe_m2reg_d = issue ? id_m2reg : 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            exe_wreg_q  <= 1'b0;
            exe_rn_q    <= '0;
            exe_m2reg_q <= 1'b0;
            mem_wreg_q  <= 1'b0;
            mem_rn_q    <= '0;
            mem_m2reg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exe_wreg_q  <= exe_wreg_d;
            exe_rn_q    <= exe_rn_d;
            exe_m2reg_q <= exe_m2reg_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_rn_q    <= mem_rn_d;
            mem_m2reg_q <= mem_m2reg_d;
        end
    end

`ifdef HAZ_STAT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!wpcir && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) stall_cnt_q <= 16'd0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
